// File: rtl/r_engine_if.sv
// R channel plus read-data FIFO push port of the DMA read-data receiver.
// The master drives R beats and FIFO full status; the slave (r_engine) returns rready and the push.
interface r_engine_if #(
    parameter int DATA_WIDTH = 64
);
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      fifo_write;
    logic [DATA_WIDTH-1:0]     fifo_data;
    logic [DATA_WIDTH/8-1:0]   fifo_keep;
    logic                      fifo_full;

    modport master (
        output rvalid, rdata, rresp, rlast, fifo_full,
        input  rready, fifo_write, fifo_data, fifo_keep
    );

    modport slave (
        input  rvalid, rdata, rresp, rlast, fifo_full,
        output rready, fifo_write, fifo_data, fifo_keep
    );
endinterface

// File: rtl/r_engine.sv
// AXI R-channel receiver: pushes each accepted beat into the read FIFO in the same cycle with a head/tail keep mask.
// rready follows !fifo_full combinationally; rlast and rresp are checked against the locally computed burst split.
module r_engine #(
    parameter int AXI_DATA_WIDTH      = 64,
    parameter int AXI_MAX_ARLEN       = 15,
    parameter int INTERNAL_ADDR_WIDTH = 32,
    parameter int BTT_WIDTH           = 23
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [INTERNAL_ADDR_WIDTH-1:0] start_addr,
    input  logic [BTT_WIDTH-1:0]           btt,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     error,
    output logic                           burst_done,
    r_engine_if.slave                      bus
);
    localparam int B    = AXI_DATA_WIDTH / 8;
    localparam int LB   = $clog2(B);
    localparam int MAXB = AXI_MAX_ARLEN + 1;
    localparam int LM   = $clog2(MAXB);
    localparam int TW   = BTT_WIDTH - LB + 1;
    localparam int CW   = LM + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   bcnt_q, bcnt_d;
    logic            first_q, first_d;
    logic [LB-1:0]   off_q, off_d;
    logic [LB-1:0]   la_q, la_d;
    logic [1:0]      err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [BTT_WIDTH:0] span;
    logic [TW-1:0]      total;
    logic [CW-1:0]      first_room;
    logic               accept;
    logic               burst_end;
    logic [B-1:0]       head_mask;
    logic [B-1:0]       tail_mask;
    logic [B-1:0]       keep;
    logic               unused_addr_bits;

    function automatic logic [CW-1:0] clamp(input logic [TW-1:0] n, input logic [CW-1:0] cap);
        return (n < TW'(cap)) ? n[CW-1:0] : cap;
    endfunction

    assign span       = {1'b0, btt} + (BTT_WIDTH+1)'(start_addr[LB-1:0]);
    assign total      = TW'(span >> LB) + TW'(span[LB-1:0] != '0);
    // Beats left before the next MAXB*B-byte boundary, i.e. the first burst's room.
    assign first_room = CW'(MAXB) - CW'(start_addr[LB+LM-1:LB]);
    assign unused_addr_bits = ^start_addr[INTERNAL_ADDR_WIDTH-1:LB+LM];

    assign bus.rready     = (state_q == RECV) && !bus.fifo_full;
    assign accept         = bus.rvalid && bus.rready;
    assign burst_end      = (bcnt_q == CW'(1));
    assign bus.fifo_write = accept;
    assign bus.fifo_data  = bus.rdata;
    assign burst_done     = accept && burst_end;

    assign head_mask = {B{1'b1}} << off_q;
    assign tail_mask = (la_q == '0) ? {B{1'b1}} : ~({B{1'b1}} << la_q);

    always_comb begin
        keep = {B{1'b1}};
        if (first_q)
            keep = keep & head_mask;
        if (rem_q == TW'(1))
            keep = keep & tail_mask;
    end
    assign bus.fifo_keep = keep;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        bcnt_d  = bcnt_q;
        first_d = first_q;
        off_d   = off_q;
        la_d    = la_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    off_d   = start_addr[LB-1:0];
                    la_d    = span[LB-1:0];
                    rem_d   = total;
                    bcnt_d  = clamp(total, first_room);
                    first_d = 1'b1;
                    err_d   = 2'b00;
                    state_d = (btt == '0) ? FINISH : RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    first_d = 1'b0;
                    rem_d   = rem_q - TW'(1);
                    bcnt_d  = bcnt_q - CW'(1);
                    if (bus.rresp != 2'b00)
                        err_d[0] = 1'b1;
                    if (bus.rlast != burst_end)
                        err_d[1] = 1'b1;
                    if (burst_end)
                        bcnt_d = clamp(rem_q - TW'(1), CW'(MAXB));
                    if (rem_q == TW'(1))
                        state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            bcnt_q  <= '0;
            first_q <= 1'b0;
            off_q   <= '0;
            la_q    <= '0;
            err_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            bcnt_q  <= bcnt_d;
            first_q <= first_d;
            off_q   <= off_d;
            la_q    <= la_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = err_q;
endmodule

// File: tb/tb_r_engine.sv
// Drives R beats for directed and random transfers and compares every cycle against a byte-address reference model.
module tb_r_engine;
    localparam int DW   = 64;
    localparam int B    = DW / 8;
    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_addr;
    logic [22:0] btt;
    logic        busy, done, burst_done;
    logic [1:0]  error;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    r_engine_if #(.DATA_WIDTH(DW)) bus();

    r_engine #(
        .AXI_DATA_WIDTH(DW), .AXI_MAX_ARLEN(MAXB-1),
        .INTERNAL_ADDR_WIDTH(32), .BTT_WIDTH(23)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .btt(btt),
        .busy(busy), .done(done), .error(error), .burst_done(burst_done), .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: beats are B-byte aligned windows covering [a, a+n).
    function automatic int m_total(input longint a, input longint n);
        return int'((n + (a % B) + B - 1) / B);
    endfunction

    function automatic bit m_end(input longint a, input longint n, input int k);
        longint base;
        base = a - (a % B);
        return (k == m_total(a, n) - 1) || (((base + longint'(k + 1) * B) % (B * MAXB)) == 0);
    endfunction

    function automatic logic [B-1:0] m_keep(input longint a, input longint n, input int k);
        logic [B-1:0] m;
        longint byte_addr;
        m = '0;
        for (int i = 0; i < B; i++) begin
            byte_addr = a - (a % B) + longint'(k) * B + i;
            m[i] = (byte_addr >= a) && (byte_addr < a + n);
        end
        return m;
    endfunction

    task automatic run_xfer(input logic [31:0] a, input int n, input bit rnd,
                            input int full_hold, input int bad_resp_k, input int bad_last_k);
        int   total, k, cyc, hold;
        logic [1:0] exp_err;
        bit   exp_last;
        total   = m_total(a, n);
        exp_err = 2'b00;
        start = 1'b1; start_addr = a; btt = 23'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_cleared_on_start", error, 2'b00);
        if (n == 0) begin
            chk("zero_done", done, 1);
            chk("zero_rready", bus.rready, 0);
            @(posedge clk); #1;
            chk("zero_done_drop", done, 0);
            chk("zero_busy_drop", busy, 0);
            return;
        end
        chk("busy_after_start", busy, 1);
        k = 0; cyc = 0; hold = 0;
        while (k < total && cyc < 4000) begin
            bus.rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (hold > 0) begin
                bus.fifo_full = 1'b1;
                hold--;
            end else begin
                bus.fifo_full = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
            end
            bus.rdata = {$urandom, $urandom};
            bus.rresp = (k == bad_resp_k) ? 2'd2 : 2'd0;
            exp_last  = m_end(a, n, k);
            bus.rlast = exp_last ^ (k == bad_last_k);
            #4;
            chk("rready", bus.rready, !bus.fifo_full);
            chk("fifo_write", bus.fifo_write, bus.rvalid && !bus.fifo_full);
            chk("done_quiet", done, 0);
            if (bus.rvalid && !bus.fifo_full) begin
                chk("fifo_data", bus.fifo_data, bus.rdata);
                chk("fifo_keep", bus.fifo_keep, m_keep(a, n, k));
                chk("burst_done", burst_done, exp_last);
                if (bus.rresp != 2'd0) exp_err[0] = 1'b1;
                if (bus.rlast != exp_last) exp_err[1] = 1'b1;
                k++;
                if (k == 1 && full_hold > 0) hold = full_hold;
            end else begin
                chk("burst_done_idle", burst_done, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("beats_before_timeout", k, total);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'd0;
        chk("done_pulse", done, 1);
        chk("busy_in_finish", busy, 1);
        chk("error_at_done", error, exp_err);
        #4;
        chk("no_burst_done_in_finish", burst_done, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        chk("error_held", error, exp_err);
    endtask

    initial begin
        int seen;
        logic [31:0] ra;
        rst = 1'b1; start = 1'b0; start_addr = '0; btt = '0;
        bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'd0; bus.rlast = 1'b0; bus.fifo_full = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_fifo_write", bus.fifo_write, 0);
        chk("rst_burst_done", burst_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_xfer(32'h1003, 20, 1'b0, 0, -1, -1);
        run_xfer(32'h0, 256, 1'b0, 0, -1, -1);
        run_xfer(32'h78, 16, 1'b0, 0, -1, -1);
        run_xfer(32'h2000, 24, 1'b0, 5, -1, -1);
        run_xfer(32'h3000, 24, 1'b0, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("error_held_idle", error, 2'b11);
        run_xfer(32'h0, 0, 1'b0, 0, -1, -1);
        run_xfer(32'h1002, 3, 1'b0, 0, -1, -1);

        for (int t = 0; t < 25; t++) begin
            ra = $urandom;
            run_xfer(ra, $urandom_range(0, 300), 1'b1, 0,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1);
        end

        // Reset in the middle of a long transfer that has already flagged an error.
        start = 1'b1; start_addr = 32'h4000; btt = 23'd200;
        @(posedge clk); #1;
        start = 1'b0;
        bus.rvalid = 1'b1; bus.fifo_full = 1'b0; bus.rresp = 2'd2; bus.rlast = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_error", error[0], 1);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rready", bus.rready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_fifo_write", bus.fifo_write, 0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("no_done_after_rst", seen, 0);
        chk("rready_idle_after_rst", bus.rready, 0);
        bus.rvalid = 1'b0; bus.rresp = 2'd0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
